md_rr_sel_ctrl: RTL

Round-robin select controller that sits directly upstream of the 4-bit 4:1 select mux in the datapath. It arbitrates among four requesting 4-bit sources and drives the mux select. One cycle later it registers the mux output into a valid/ready output stage and returns a one-hot acknowledge to the granted source. It turns the purely combinational mux into a sequenced, back-pressurable 4-channel collector.

---
 rtl/md_rr_sel_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/md_rr_sel_ctrl.sv
// md_rr_sel_ctrl
//
// Round-robin select controller in front of a 4-bit 4:1 select mux.
// It picks one of four requesting sources and drives the mux select.
// One cycle later it captures the mux output into a valid/ready output
// register and pulses a one-hot ack back to the granted source.
//
// Build option:
//   MD_RR_FAIR_EN  defined   -> round-robin arbitration starting after last_grant
//                  undefined -> fixed priority, channel 0 highest, channel 3 lowest
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   req        in   4  per-channel request, bit i = source i has data on mux input i
//   sel        out  2  registered mux select (0=a, 1=b, 2=c, 3=d)
//   mux_y      in   4  combinational mux output for the current sel
//   out_data   out  4  captured data word
//   out_valid  out  1  out_data holds an unconsumed word
//   out_ready  in   1  consumer takes out_data when out_valid is high
//   ack        out  4  one-hot single-cycle pulse for the captured channel
//
// state  | meaning
// IDLE   | no word in flight; waiting for any req
// SAMPLE | sel is stable, mux_y settles; captured at the end of this cycle
// HOLD   | out_data valid; waiting for out_ready, then re-arbitrate or idle

module md_rr_sel_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] sel,
    input  logic [3:0] mux_y,
    output logic [3:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] data_nxt;
    logic       valid_nxt;
    logic [3:0] ack_nxt;
    logic [1:0] winner;

`ifdef MD_RR_FAIR_EN
    logic [1:0] last_grant, last_grant_nxt;

    // Search last+1 .. last+4; the 2-bit sum wraps 3->0, and the +4 step
    // lands back on last so a lone requester can win repeatedly.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner = pick(req, last_grant);
`else
    function automatic logic [1:0] pick(input logic [3:0] r);
        logic [1:0] win;
        if (r[0])      win = 2'd0;
        else if (r[1]) win = 2'd1;
        else if (r[2]) win = 2'd2;
        else if (r[3]) win = 2'd3;
        else           win = 2'd0;
        return win;
    endfunction

    assign winner = pick(req);
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        data_nxt  = out_data;
        valid_nxt = out_valid;
        ack_nxt   = 4'b0000;
`ifdef MD_RR_FAIR_EN
        last_grant_nxt = last_grant;
`endif
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_nxt   = winner;
`ifdef MD_RR_FAIR_EN
                    last_grant_nxt = winner;
`endif
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // req is deliberately not re-checked: the grant is committed.
                data_nxt  = mux_y;
                valid_nxt = 1'b1;
                ack_nxt   = 4'b0001 << sel;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    if (req != 4'b0000) begin
                        sel_nxt   = winner;
`ifdef MD_RR_FAIR_EN
                        last_grant_nxt = winner;
`endif
                        state_nxt = SAMPLE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'b00;
            out_data  <= 4'h0;
            out_valid <= 1'b0;
            ack       <= 4'b0000;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
            ack       <= ack_nxt;
        end
    end

`ifdef MD_RR_FAIR_EN
    // Reset to 3 so the first search starts at channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= 2'b11;
        else        last_grant <= last_grant_nxt;
    end
`endif

endmodule
